// File: rtl/display_ctrl.sv
// display_ctrl: four-digit debug display sequencer, PC and a selected register shown as decimal.
// Optional DISPLAY_FREEZE_EN adds a freeze input that keeps IDLE from starting new conversions.
module display_ctrl #(
  parameter int REFRESH_CYCLES  = 5000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_REGS        = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc,
  input  logic [7:0] reg_data,
  input  logic       key_next,
`ifdef DISPLAY_FREEZE_EN
  input  logic       freeze,
`endif
  output logic [4:0] reg_addr,
  output logic [3:0] pc1,
  output logic [3:0] pc2,
  output logic [3:0] reg1,
  output logic [3:0] reg2,
  output logic       busy
);
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, CAPTURE, CONVERT, UPDATE} state_t;
  state_t state_q, state_d;
  logic key_s1_q, key_s2_q, key_q, key_d;
  logic [DW-1:0] db_q, db_d;
  logic [RW-1:0] ref_q, ref_d;
  logic pend_q, pend_d;
  logic [2:0] it_q, it_d;
  logic [7:0] pc_sh_q, pc_sh_d, rg_sh_q, rg_sh_d;
  logic [11:0] pc_bcd_q, pc_bcd_d, rg_bcd_q, rg_bcd_d;
  logic [4:0] addr_q, addr_d;
  logic [15:0] disp_q, disp_d;
  logic frz, press, wrap, go;
`ifdef DISPLAY_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif
  // one double-dabble step on {bcd[11:0], shift[7:0]}
  function automatic logic [19:0] dd(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int i = 0; i < 3; i++)
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    return t << 1;
  endfunction
  function automatic logic [7:0] digits(input logic [11:0] bcd);
    return (bcd[11:8] != 4'd0) ? 8'hFF : bcd[7:0];
  endfunction
  assign wrap  = ref_q == RW'(REFRESH_CYCLES - 1);
  assign press = key_q && !key_s2_q && db_q == DW'(DEBOUNCE_CYCLES - 1);
  assign go    = state_q == IDLE && pend_q && !frz;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = go ? CAPTURE : IDLE;
      CAPTURE: state_d = CONVERT;
      CONVERT: state_d = (it_q == 3'd7) ? UPDATE : CONVERT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy     = state_q != IDLE;
    reg_addr = addr_q;
    {pc2, pc1, reg2, reg1} = disp_q;
  end
  always_comb begin
    key_d    = key_q;
    db_d     = '0;
    if (key_s2_q != key_q) begin
      db_d = db_q + 1'b1;
      if (db_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        key_d = key_s2_q;
        db_d  = '0;
      end
    end
    ref_d    = wrap ? '0 : ref_q + 1'b1;
    addr_d   = press ? ((addr_q == 5'(NUM_REGS - 1)) ? 5'd0 : addr_q + 5'd1) : addr_q;
    pend_d   = (pend_q && !go) || press || wrap;
    pc_sh_d  = pc_sh_q;
    rg_sh_d  = rg_sh_q;
    pc_bcd_d = pc_bcd_q;
    rg_bcd_d = rg_bcd_q;
    it_d     = it_q;
    disp_d   = disp_q;
    if (state_q == CAPTURE) begin
      pc_sh_d  = pc;
      rg_sh_d  = reg_data;
      pc_bcd_d = '0;
      rg_bcd_d = '0;
      it_d     = '0;
    end
    if (state_q == CONVERT) begin
      {pc_bcd_d, pc_sh_d} = dd({pc_bcd_q, pc_sh_q});
      {rg_bcd_d, rg_sh_d} = dd({rg_bcd_q, rg_sh_q});
      it_d = it_q + 3'd1;
    end
    if (state_q == UPDATE) disp_d = {digits(pc_bcd_q), digits(rg_bcd_q)};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      key_q    <= 1'b1;
      db_q     <= '0;
      ref_q    <= '0;
      pend_q   <= 1'b1;
      it_q     <= '0;
      pc_sh_q  <= '0;
      rg_sh_q  <= '0;
      pc_bcd_q <= '0;
      rg_bcd_q <= '0;
      addr_q   <= '0;
      disp_q   <= 16'hFFFF;
    end else begin
      key_s1_q <= key_next;
      key_s2_q <= key_s1_q;
      key_q    <= key_d;
      db_q     <= db_d;
      ref_q    <= ref_d;
      pend_q   <= pend_d;
      it_q     <= it_d;
      pc_sh_q  <= pc_sh_d;
      rg_sh_q  <= rg_sh_d;
      pc_bcd_q <= pc_bcd_d;
      rg_bcd_q <= rg_bcd_d;
      addr_q   <= addr_d;
      disp_q   <= disp_d;
    end
  end
endmodule

// File: tb/tb_display_ctrl.sv
// tb_display_ctrl: randomized bench for display_ctrl against a countdown-based behavioural model.
module tb_display_ctrl;
  localparam int RC = 64, DC = 4, NR = 32;
  logic clk = 0, reset = 1, key_next = 1, freeze = 0;
  logic [7:0] pc = 8'd37;
  logic [7:0] regs [NR];
  logic [7:0] reg_data;
  logic [4:0] reg_addr;
  logic [3:0] pc1, pc2, reg1, reg2;
  logic busy;
  int n_err = 0, n_chk = 0, exp_addr;
  assign reg_data = regs[reg_addr];
  always #5 clk = ~clk;
  display_ctrl #(.REFRESH_CYCLES(RC), .DEBOUNCE_CYCLES(DC), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .pc(pc), .reg_data(reg_data), .key_next(key_next),
`ifdef DISPLAY_FREEZE_EN
    .freeze(freeze),
`endif
    .reg_addr(reg_addr), .pc1(pc1), .pc2(pc2), .reg1(reg1), .reg2(reg2), .busy(busy));
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int tens(input int v);
    return v > 99 ? 15 : v / 10;
  endfunction
  function automatic int ones(input int v);
    return v > 99 ? 15 : v % 10;
  endfunction
  // model: key history, a 10-cycle busy countdown and decimal arithmetic on captured values
  int m_s1, m_s2, m_key, m_stab, m_tick, m_left, m_pend, m_addr, m_pv, m_rv;
  int m_pt, m_po, m_rt, m_ro;
  bit m_press, m_wrap;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = 1; m_s2 = 1; m_key = 1; m_stab = 0; m_tick = 0; m_left = 0; m_pend = 1; m_addr = 0;
      m_pt = 15; m_po = 15; m_rt = 15; m_ro = 15;
    end else begin
      m_press = 0;
      if (m_s2 != m_key) begin
        m_stab++;
        if (m_stab == DC) begin
          m_key = m_s2; m_stab = 0; m_press = (m_key == 0);
        end
      end else m_stab = 0;
      m_s2 = m_s1; m_s1 = int'(key_next);
      m_wrap = (m_tick == RC - 1);
      m_tick = m_wrap ? 0 : m_tick + 1;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 9) begin m_pv = int'(pc); m_rv = int'(regs[m_addr]); end
        if (m_left == 0) begin
          m_pt = tens(m_pv); m_po = ones(m_pv); m_rt = tens(m_rv); m_ro = ones(m_rv);
        end
      end else if (m_pend == 1 && !freeze) begin
        m_pend = 0; m_left = 10;
      end
      if (m_press) m_addr = (m_addr + 1) % NR;
      if (m_press || m_wrap) m_pend = 1;
    end
  end
  always @(negedge clk) if (!reset) begin
    check("sb_addr", reg_addr, m_addr);
    check("sb_pc1", pc1, m_po);
    check("sb_pc2", pc2, m_pt);
    check("sb_reg1", reg1, m_ro);
    check("sb_reg2", reg2, m_rt);
    check("sb_busy", busy, int'(m_left > 0));
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_busy(input logic lvl, input string tag);
    int k = 0;
    while (busy !== lvl && k < 300) begin @(negedge clk); k++; end
    check(tag, int'(busy === lvl), 1);
  endtask
  task automatic do_press(input int bounce);
    repeat (bounce) begin
      key_next = 0; cyc(1 + $urandom_range(0, 1)); key_next = 1; cyc(1);
    end
    key_next = 0; cyc(10); key_next = 1; cyc(10);
    exp_addr = (exp_addr + 1) % NR;
    check("press_addr", reg_addr, exp_addr);
  endtask
  initial begin
    foreach (regs[i]) regs[i] = 8'($urandom);
    regs[0] = 8'd5;
    exp_addr = 0;
    cyc(3);
    check("rst_pc1", pc1, 15); check("rst_pc2", pc2, 15);
    check("rst_reg1", reg1, 15); check("rst_reg2", reg2, 15);
    check("rst_addr", reg_addr, 0); check("rst_busy", busy, 0);
    reset = 0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      check("lat_busy", busy, int'(i < 10));
      check("lat_pc1", pc1, i < 10 ? 15 : 7);
    end
    check("first_pc2", pc2, 3); check("first_reg2", reg2, 0); check("first_reg1", reg1, 5);
    pc = 8'd99; regs[0] = 8'd100;
    wait_busy(1, "wait_r1"); wait_busy(0, "wait_r1e");
    check("v99_pc2", pc2, 9); check("v99_pc1", pc1, 9);
    check("v100_reg2", reg2, 15); check("v100_reg1", reg1, 15);
    regs[0] = 8'd0;
    wait_busy(1, "wait_r2"); wait_busy(0, "wait_r2e");
    check("v0_reg2", reg2, 0); check("v0_reg1", reg1, 0);
    key_next = 0; cyc(2); key_next = 1; cyc(2); key_next = 0; cyc(2); key_next = 1; cyc(1);
    key_next = 0; cyc(40);
    check("hold_once", reg_addr, 1);
    key_next = 1; cyc(10);
    check("release_noop", reg_addr, 1);
    exp_addr = 1;
    for (int i = 0; i < 31; i++) begin
      regs[(exp_addr + 1) % NR] = 8'($urandom);
      do_press($urandom_range(0, 2));
    end
    check("wrap_addr", reg_addr, 0);
    wait_busy(0, "wait_idle5");
    regs[exp_addr] = 8'd12; regs[(exp_addr + 1) % NR] = 8'd45;
    wait_busy(1, "wait_r5");
    key_next = 0;
    wait_busy(0, "wait_r5e");
    check("mid_reg2", reg2, 1); check("mid_reg1", reg1, 2);
    @(negedge clk);
    check("mid_restart", busy, 1);
    wait_busy(0, "wait_r6e");
    check("new_reg2", reg2, 4); check("new_reg1", reg1, 5);
    key_next = 1; cyc(10);
    exp_addr = (exp_addr + 1) % NR;
`ifdef DISPLAY_FREEZE_EN
    wait_busy(0, "wait_frz");
    freeze = 1; pc = 8'd42;
    cyc(2 * RC);
    check("frz_busy", busy, 0); check("frz_pc1", pc1, 9);
    freeze = 0;
    @(negedge clk);
    check("frz_resume", busy, 1);
    wait_busy(0, "wait_frz_e");
    check("frz_pc2", pc2, 4);
`endif
    wait_busy(1, "wait_rst");
    cyc(3); #2 reset = 1; #1;
    check("arst_pc1", pc1, 15); check("arst_pc2", pc2, 15);
    check("arst_reg1", reg1, 15); check("arst_reg2", reg2, 15);
    check("arst_addr", reg_addr, 0); check("arst_busy", busy, 0);
    cyc(2); reset = 0;
    cyc(30);
    repeat (150) begin
      key_next = 1'($urandom);
      if ($urandom_range(0, 3) == 0) pc = 8'($urandom);
      regs[$urandom_range(0, NR - 1)] = 8'($urandom_range(0, 1) ? $urandom_range(0, 99) : $urandom);
      cyc($urandom_range(1, 12));
    end
    key_next = 1; cyc(40);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
